// File: rtl/stream_fork_fifo.sv
// Per-branch FIFO for stream_fork2. The pointers wrap naturally and occupancy runs
// from 0 to DEPTH. Head data is forced to zero while rst is high.
module stream_fork_fifo #(
  parameter int unsigned DW    = 11,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          rdy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] OccFull = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (occ_q == OccFull);
  assign rdy     = !rst && (occ_q != '0);
  assign dout    = rst ? '0 : mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && rdy;

  always_comb begin
    occ_d = occ_q;
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/stream_fork2.sv
// Fork one rdy/ack stream into two identical streams, each with its own FIFO.
// The source is accepted only when neither branch is full, judged from registered state.
module stream_fork2 #(
  parameter int unsigned DW    = 11,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_rdy,
  output logic          src_ack,
  input  logic [DW-1:0] src_dat,
  output logic          dst0_rdy,
  input  logic          dst0_ack,
  output logic [DW-1:0] dst0_dat,
  output logic          dst1_rdy,
  input  logic          dst1_ack,
  output logic [DW-1:0] dst1_dat,
  output logic [CW-1:0] xfer_cnt
);
  logic          full0, full1, accept;
  logic [CW-1:0] xfer_cnt_q;

  assign src_ack  = !rst && !full0 && !full1;
  assign accept   = src_rdy && src_ack;
  assign xfer_cnt = xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)         xfer_cnt_q <= '0;
    else if (accept) xfer_cnt_q <= xfer_cnt_q + CW'(1);
  end

  stream_fork_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .din  (src_dat),
    .full (full0),
    .pop  (dst0_ack),
    .dout (dst0_dat),
    .rdy  (dst0_rdy)
  );

  stream_fork_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .din  (src_dat),
    .full (full1),
    .pop  (dst1_ack),
    .dout (dst1_dat),
    .rdy  (dst1_rdy)
  );
endmodule
